game_ctrl: RTL

- Frame-rate game-flow sequencer for the Pac-Man datapath.
- Drives the player-movement block's restart and lifeDown inputs, and gates motion through move_en.
- Tracks lives and level, and sequences the IDLE/READY/PLAY/DYING/CLEAR/OVER phases from start key, ghost collision and dots-cleared events.
- Sits between the keyboard/collision/dot logic and the player, ghost and HUD blocks.

---
 rtl/game_ctrl_if.sv | 26 ++
 rtl/game_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Game-flow signal bundle between the input-side logic (keyboard, collision, dots)
// and the game_ctrl sequencer, whose outputs feed the player, ghost and HUD blocks.
interface game_ctrl_if;
  logic [7:0] keycode;
  logic       ghost_hit;
  logic       dots_zero;
  logic       restart;
  logic       lifeDown;
  logic       move_en;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state;
  logic       game_over;

  // Events are sampled as plain levels on every frame_clk edge; there is no
  // valid/ready handshake, so each frame's inputs are consumed exactly once.
  modport master (
    output keycode, ghost_hit, dots_zero,
    input  restart, lifeDown, move_en, lives, level, state, game_over
  );

  modport slave (
    input  keycode, ghost_hit, dots_zero,
    output restart, lifeDown, move_en, lives, level, state, game_over
  );
endinterface

// File: rtl/game_ctrl.sv
// Frame-rate game-flow sequencer: start key, death and level-clear phases,
// lives/level bookkeeping and the restart/lifeDown pulses for the datapath.
module game_ctrl #(
  parameter int         LIVES_INIT   = 3,
  parameter int         READY_FRAMES = 120,
  parameter int         DEATH_FRAMES = 90,
  parameter int         CLEAR_FRAMES = 120,
  parameter logic [7:0] KEY_START    = 8'h2C
) (
  input  logic       Reset,
  input  logic       frame_clk,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [7:0] T_READY    = 8'(READY_FRAMES - 1);
  localparam logic [7:0] T_DEATH    = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] T_CLEAR    = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_t     st;
  logic [7:0] timer;
  logic [7:0] key_prev;
  logic [1:0] lives_r;
  logic [3:0] level_r;
  logic       restart_r;
  logic       lifedown_r;
  logic       move_en_r;
  logic       game_over_r;
  logic       start;

  // Edge on the start key, so a held key only starts one game.
  assign start = (bus.keycode == KEY_START) && (key_prev != KEY_START);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st          <= IDLE;
      timer       <= 8'd0;
      key_prev    <= 8'h00;
      lives_r     <= LIVES_LOAD;
      level_r     <= 4'd0;
      restart_r   <= 1'b0;
      lifedown_r  <= 1'b0;
      move_en_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      key_prev   <= bus.keycode;
      restart_r  <= 1'b0;
      lifedown_r <= 1'b0;
      move_en_r  <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (start) begin
            st          <= READY;
            restart_r   <= 1'b1;
            lives_r     <= LIVES_LOAD;
            level_r     <= 4'd0;
            timer       <= T_READY;
            game_over_r <= 1'b0;
          end
        end
        READY: begin
          if (timer == 8'd0) begin
            st        <= PLAY;
            move_en_r <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        PLAY: begin
          // Clearing the maze wins over a same-frame ghost collision.
          if (bus.dots_zero) begin
            st    <= CLEAR;
            timer <= T_CLEAR;
          end else if (bus.ghost_hit) begin
            st    <= DYING;
            timer <= T_DEATH;
          end else begin
            move_en_r <= 1'b1;
          end
        end
        DYING: begin
          if (timer == 8'd0) begin
            if (lives_r == 2'd1) begin
              lives_r     <= 2'd0;
              st          <= OVER;
              game_over_r <= 1'b1;
            end else begin
              lives_r    <= lives_r - 2'd1;
              lifedown_r <= 1'b1;
              st         <= READY;
              timer      <= T_READY;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        CLEAR: begin
          if (timer == 8'd0) begin
            if (level_r != 4'd15) level_r <= level_r + 4'd1;
            restart_r <= 1'b1;
            st        <= READY;
            timer     <= T_READY;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.lives     = lives_r;
  assign bus.level     = level_r;
  assign bus.restart   = restart_r;
  assign bus.lifeDown  = lifedown_r;
  assign bus.move_en   = move_en_r;
  assign bus.game_over = game_over_r;

endmodule
